// File: rtl/gnn_pkg.sv
// Shared definitions for the GNN batch sequencer slice.
// Holds the data widths, bus packing helpers, timing limits and the
// sequencer state encoding.
package gnn_pkg;

    localparam int FEAT_W     = 5;
    localparam int OUT_W      = 21;
    localparam int N_NODE     = 4;
    localparam int N_FEAT     = 4;
    localparam int N_OUT      = 2;
    localparam int N_RES      = N_NODE * N_OUT;
    localparam int N_W        = 24;
    localparam int FEAT_BUS_W = N_NODE * N_FEAT * FEAT_W;
    localparam int W_BUS_W    = N_W * FEAT_W;
    localparam int RES_BUS_W  = N_RES * OUT_W;
    localparam int TIMEOUT    = 31;
    localparam int GAP_CYC    = 2;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

    // Bit offset of feature f of node n inside the packed feature bus.
    function automatic int feat_idx(input int n, input int f);
        return (n * N_FEAT + f) * FEAT_W;
    endfunction

    // Result slot index of output o of node n (slot k lives at k*OUT_W).
    function automatic int res_idx(input int n, input int o);
        return n * N_OUT + o;
    endfunction

endpackage

// File: rtl/gnn_ready_collector.sv
// Collects the engine's per-result ready flags for one batch.
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        clears mask and captured data (start of a batch)
//   en         collection enabled (sequencer is running the engine)
//   rdy        per-result ready flags from the engine
//   res        packed engine results
//   data       captured results, slot k held from its first ready cycle
//   full       every flag seen, including the flags present this cycle
module gnn_ready_collector
    import gnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [N_RES-1:0]     rdy,
    input  logic [RES_BUS_W-1:0] res,
    output logic [RES_BUS_W-1:0] data,
    output logic                 full
);

    logic [N_RES-1:0] mask;

    assign full = &(mask | rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            data <= '0;
        end else if (clr) begin
            mask <= '0;
            data <= '0;
        end else if (en) begin
            mask <= mask | rdy;
            // Only the first ready cycle of a slot is captured; later
            // cycles (or repeated pulses) must not disturb the result.
            for (int n = 0; n < N_NODE; n++) begin
                for (int o = 0; o < N_OUT; o++) begin
                    if (rdy[res_idx(n, o)] && !mask[res_idx(n, o)]) begin
                        data[res_idx(n, o) * OUT_W +: OUT_W] <= res[res_idx(n, o) * OUT_W +: OUT_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gnn_batch_sequencer.sv
// Sequences the 4-node GNN engine over a stream of graph batches.
// Ports:
//   clk, rst                    clock, async active-high reset
//   s_valid/s_ready/s_feat      batch feature input handshake
//   w_load/w_data               weight bank load
//   eng_x/eng_w/eng_in_ready    registered engine drive
//   eng_rdy/eng_res             engine ready flags and results
//   m_valid/m_ready             result handshake
//   m_data/m_err/m_lat          captured results, timeout flag, RUN cycles used
//
// state | meaning
// IDLE  | waiting for a batch; weights may be loaded directly
// RUN   | engine started, collecting ready flags, counting cycles
// OUT   | result word presented until accepted
// GAP   | engine held off until the gap elapsed and all flags dropped
module gnn_batch_sequencer
    import gnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FEAT_BUS_W-1:0] s_feat,
    input  logic                  w_load,
    input  logic [W_BUS_W-1:0]    w_data,
    output logic [FEAT_BUS_W-1:0] eng_x,
    output logic [W_BUS_W-1:0]    eng_w,
    output logic                  eng_in_ready,
    input  logic [N_RES-1:0]      eng_rdy,
    input  logic [RES_BUS_W-1:0]  eng_res,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RES_BUS_W-1:0]  m_data,
    output logic                  m_err,
    output logic [CNT_W-1:0]      m_lat
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [1:0]       GAP_LAST  = 2'(GAP_CYC - 1);

    seq_state_t         state;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [1:0]         gap_cnt;
    logic               w_pend;
    logic [W_BUS_W-1:0] w_shadow;
    logic               accept;
    logic               col_full;

    assign s_ready  = (state == IDLE) && !w_pend;
    assign accept   = s_valid && s_ready;
    // Count of RUN cycles including the current one, saturating.
    assign cnt_next = (run_cnt == TIMEOUT_C) ? run_cnt : run_cnt + CNT_W'(1);

    gnn_ready_collector u_collector (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state == RUN),
        .rdy  (eng_rdy),
        .res  (eng_res),
        .data (m_data),
        .full (col_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eng_x        <= '0;
            eng_w        <= '0;
            eng_in_ready <= 1'b0;
            m_valid      <= 1'b0;
            m_err        <= 1'b0;
            m_lat        <= '0;
            run_cnt      <= '0;
            gap_cnt      <= '0;
            w_pend       <= 1'b0;
            w_shadow     <= '0;
        end else begin
            // Weights change only between batches; anything arriving while
            // a batch is in flight is parked until the GAP exit.
            if (w_load) begin
                if (state == IDLE && !w_pend) begin
                    eng_w <= w_data;
                end else begin
                    w_shadow <= w_data;
                    w_pend   <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_x        <= s_feat;
                        run_cnt      <= '0;
                        eng_in_ready <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= cnt_next;
                    if (col_full) begin
                        state        <= OUT;
                        eng_in_ready <= 1'b0;
                        m_valid      <= 1'b1;
                        m_err        <= 1'b0;
                        m_lat        <= cnt_next;
                    end else if (cnt_next == TIMEOUT_C) begin
                        state        <= OUT;
                        eng_in_ready <= 1'b0;
                        m_valid      <= 1'b1;
                        m_err        <= 1'b1;
                        m_lat        <= cnt_next;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST && eng_rdy == '0) begin
                        state <= IDLE;
                        // A load on the exit edge is newer than the shadow.
                        if (w_load) begin
                            eng_w <= w_data;
                        end else if (w_pend) begin
                            eng_w <= w_shadow;
                        end
                        w_pend <= 1'b0;
                    end else if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
